rf_wb_arbiter: RTL and testbench

//  Shares the register file's single write-back port (writeBackEn/Dest_wb/Result_WB)

---
 rtl/rf_pkg.sv | 13 +
 rtl/wb_fifo.sv | 40 ++++
 rtl/rf_wb_arbiter.sv | 102 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Types shared by the register-file write-back arbiter and its source FIFOs.
package rf_pkg;
    localparam int REG_NUM    = 16;
    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    typedef enum logic {SRC_EXE, SRC_MEM} wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries; pointers carry one wrap bit above the index.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output wb_entry_t head,
    output logic      empty,
    output logic      full
);
    localparam int AW = $clog2(DEPTH);

    wb_entry_t      mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin merge of EXE and MEM write-backs onto the single RF write port,
// with per-register pending-write counters feeding the hazard unit.
module rf_wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_valid,
    output logic              exe_ready,
    input  logic [ADDR_W-1:0] exe_dest,
    input  logic [DATA_W-1:0] exe_result,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_result,
    output logic              writeBackEn,
    output logic [ADDR_W-1:0] Dest_wb,
    output logic [DATA_W-1:0] Result_WB,
    output logic [15:0]       busy_mask
);
    import rf_pkg::*;

    localparam int CNT_W = $clog2(2*DEPTH+2);

    wb_entry_t        exe_in, mem_in, exe_head, mem_head;
    logic             exe_empty, exe_full, mem_empty, mem_full;
    logic             exe_push, mem_push, exe_pop, mem_pop;
    wb_src_e          rr_last;
    logic [CNT_W-1:0] cnt      [REG_NUM];
    logic [CNT_W-1:0] cnt_next [REG_NUM];

    assign exe_ready = !exe_full;
    assign mem_ready = !mem_full;
    assign exe_push  = exe_valid && exe_ready;
    assign mem_push  = mem_valid && mem_ready;
    assign exe_in    = '{dest: exe_dest, data: exe_result};
    assign mem_in    = '{dest: mem_dest, data: mem_result};

    wb_fifo #(.DEPTH(DEPTH)) u_exe_fifo (
        .clk(clk), .rst(rst), .push(exe_push), .push_data(exe_in),
        .pop(exe_pop), .head(exe_head), .empty(exe_empty), .full(exe_full)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .clk(clk), .rst(rst), .push(mem_push), .push_data(mem_in),
        .pop(mem_pop), .head(mem_head), .empty(mem_empty), .full(mem_full)
    );

    // rr_last only moves when both sources actually compete.
    assign exe_pop = !exe_empty && (mem_empty || rr_last == SRC_MEM);
    assign mem_pop = !mem_empty && (exe_empty || rr_last == SRC_EXE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= SRC_MEM;
        end else if (!exe_empty && !mem_empty) begin
            rr_last <= exe_pop ? SRC_EXE : SRC_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            writeBackEn <= 1'b0;
            Dest_wb     <= '0;
            Result_WB   <= '0;
        end else if (exe_pop) begin
            writeBackEn <= 1'b1;
            Dest_wb     <= exe_head.dest;
            Result_WB   <= exe_head.data;
        end else if (mem_pop) begin
            writeBackEn <= 1'b1;
            Dest_wb     <= mem_head.dest;
            Result_WB   <= mem_head.data;
        end else begin
            writeBackEn <= 1'b0;
        end
    end

    // A write retires at the edge that ends its port cycle; netted with new pushes.
    always_comb begin
        for (int r = 0; r < REG_NUM; r++) begin
            cnt_next[r] = cnt[r];
            if (exe_push && exe_dest == ADDR_W'(r)) cnt_next[r] = cnt_next[r] + CNT_W'(1);
            if (mem_push && mem_dest == ADDR_W'(r)) cnt_next[r] = cnt_next[r] + CNT_W'(1);
            if (writeBackEn && Dest_wb == ADDR_W'(r)) cnt_next[r] = cnt_next[r] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < REG_NUM; r++) begin
            if (rst) cnt[r] <= '0;
            else     cnt[r] <= cnt_next[r];
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int r = 0; r < REG_NUM; r++) busy_mask[r] = (cnt[r] != '0);
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_rf_wb_arbiter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_valid, mem_valid;
    logic        exe_ready, mem_ready;
    logic [3:0]  exe_dest, mem_dest;
    logic [31:0] exe_result, mem_result;
    logic        writeBackEn;
    logic [3:0]  Dest_wb;
    logic [31:0] Result_WB;
    logic [15:0] busy_mask;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_dest(exe_dest), .exe_result(exe_result),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_result(mem_result),
        .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .Result_WB(Result_WB), .busy_mask(busy_mask)
    );

    typedef struct {
        int          d;
        logic [31:0] v;
    } ent_t;

    ent_t        qe[$];
    ent_t        qm[$];
    int          m_cnt [16];
    bit          m_en;
    int          m_dest;
    logic [31:0] m_data;
    bit          m_mem_last;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [3:0]  log_d[$];
    logic [31:0] log_v[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // One clock edge of the reference: pending writes kept as queues and plain integer counts.
    task automatic model_step(input bit r, input bit ev, input int ed, input logic [31:0] er,
                              input bit mv, input int md, input logic [31:0] mr);
        bit   acc_e, acc_m, have;
        ent_t g;
        if (r) begin
            qe.delete();
            qm.delete();
            m_en = 0; m_dest = 0; m_data = '0; m_mem_last = 1;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            return;
        end
        acc_e = ev && (qe.size() < DEPTH);
        acc_m = mv && (qm.size() < DEPTH);
        have  = 1;
        if (qe.size() > 0 && qm.size() > 0) begin
            if (m_mem_last) g = qe.pop_front();
            else            g = qm.pop_front();
            m_mem_last = !m_mem_last;
        end else if (qe.size() > 0) begin
            g = qe.pop_front();
        end else if (qm.size() > 0) begin
            g = qm.pop_front();
        end else begin
            have = 0;
        end
        if (m_en) m_cnt[m_dest]--;
        m_en = have;
        if (have) begin
            m_dest = g.d;
            m_data = g.v;
        end
        if (acc_e) begin
            qe.push_back('{d: ed, v: er});
            m_cnt[ed]++;
        end
        if (acc_m) begin
            qm.push_back('{d: md, v: mr});
            m_cnt[md]++;
        end
    endtask

    task automatic tick(input bit r, input bit ev, input int ed, input logic [31:0] er,
                        input bit mv, input int md, input logic [31:0] mr);
        logic [15:0] exp_mask;
        rst        = r;
        exe_valid  = ev;
        exe_dest   = 4'(ed);
        exe_result = er;
        mem_valid  = mv;
        mem_dest   = 4'(md);
        mem_result = mr;
        model_step(r, ev, ed, er, mv, md, mr);
        @(negedge clk);
        exp_mask = '0;
        for (int i = 0; i < 16; i++) exp_mask[i] = (m_cnt[i] != 0);
        check("m_wb_en",     {31'b0, writeBackEn}, {31'b0, m_en});
        check("m_dest",      {28'b0, Dest_wb}, 32'(m_dest));
        check("m_result",    Result_WB, m_data);
        check("m_busy",      {16'b0, busy_mask}, {16'b0, exp_mask});
        check("m_exe_ready", {31'b0, exe_ready}, {31'b0, qe.size() < DEPTH});
        check("m_mem_ready", {31'b0, mem_ready}, {31'b0, qm.size() < DEPTH});
        if (writeBackEn) begin
            log_d.push_back(Dest_wb);
            log_v.push_back(Result_WB);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            tick(0, 0, $urandom_range(15), $urandom, 0, $urandom_range(15), $urandom);
    endtask

    task automatic do_reset();
        tick(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit saw;

        // Reset state
        do_reset();
        check("rst_wb_en",     {31'b0, writeBackEn}, 32'd0);
        check("rst_busy",      {16'b0, busy_mask}, 32'd0);
        check("rst_exe_ready", {31'b0, exe_ready}, 32'd1);
        check("rst_mem_ready", {31'b0, mem_ready}, 32'd1);

        // Single push, two-edge latency, then idle hold
        tick(0, 1, 3, 32'hDEADBEEF, 0, 0, 0);
        check("single_busy_q",  {31'b0, busy_mask[3]}, 32'd1);
        check("single_en_q",    {31'b0, writeBackEn}, 32'd0);
        idle(1);
        check("single_en",      {31'b0, writeBackEn}, 32'd1);
        check("single_dest",    {28'b0, Dest_wb}, 32'd3);
        check("single_data",    Result_WB, 32'hDEADBEEF);
        check("single_busy_wb", {31'b0, busy_mask[3]}, 32'd1);
        idle(1);
        check("idle_en",        {31'b0, writeBackEn}, 32'd0);
        check("idle_busy",      {16'b0, busy_mask}, 32'd0);
        check("idle_dest",      {28'b0, Dest_wb}, 32'd3);
        check("idle_data",      Result_WB, 32'hDEADBEEF);

        // Contention: grants alternate starting with EXE, nothing lost or duplicated
        do_reset();
        log_d.delete();
        log_v.delete();
        for (int k = 0; k < 6; k++)
            tick(0, 1, 1 + k, 32'h100 + k, 1, 8 + k, 32'h200 + k);
        idle(10);
        check("cont_count", 32'(log_d.size()), 32'd12);
        for (int i = 0; i < 12 && i < log_d.size(); i++) begin
            check("cont_dest", {28'b0, log_d[i]}, (i % 2 == 0) ? 32'(1 + i/2) : 32'(8 + i/2));
            check("cont_data", log_v[i], (i % 2 == 0) ? 32'h100 + 32'(i/2) : 32'h200 + 32'(i/2));
        end

        // Full: both sources saturate, EXE fills at half drain rate
        do_reset();
        saw = 0;
        for (int k = 0; k < 20 && !saw; k++) begin
            tick(0, 1, k % 8, 32'(k), 1, 8 + (k % 7), 32'(k) ^ 32'hFFFF);
            if (!exe_ready) saw = 1;
        end
        check("full_seen", {31'b0, saw}, 32'd1);
        tick(0, 1, 15, 32'h5555, 0, 0, 0);
        check("full_reject", {31'b0, busy_mask[15]}, 32'd0);
        saw = 0;
        for (int k = 0; k < 4 && !saw; k++) begin
            idle(1);
            if (exe_ready) saw = 1;
        end
        check("full_recover", {31'b0, saw}, 32'd1);

        // Reset while queues hold traffic
        do_reset();
        check("mid_rst_wb_en",     {31'b0, writeBackEn}, 32'd0);
        check("mid_rst_busy",      {16'b0, busy_mask}, 32'd0);
        check("mid_rst_exe_ready", {31'b0, exe_ready}, 32'd1);
        check("mid_rst_mem_ready", {31'b0, mem_ready}, 32'd1);
        idle(2);
        check("mid_rst_no_write",  {31'b0, writeBackEn}, 32'd0);

        // Same register queued twice
        do_reset();
        tick(0, 1, 5, 32'hA, 0, 0, 0);
        tick(0, 1, 5, 32'hB, 0, 0, 0);
        check("r5_busy_two", {31'b0, busy_mask[5]}, 32'd1);
        check("r5_first",    Result_WB, 32'hA);
        idle(1);
        check("r5_second",   Result_WB, 32'hB);
        check("r5_busy_one", {31'b0, busy_mask[5]}, 32'd1);
        idle(1);
        check("r5_clear",    {31'b0, busy_mask[5]}, 32'd0);

        // Push r5 at the edge that retires a prior r5 write
        do_reset();
        tick(0, 1, 5, 32'hC, 0, 0, 0);
        idle(1);
        check("net_wb_c",   Result_WB, 32'hC);
        tick(0, 1, 5, 32'hD, 0, 0, 0);
        check("net_busy",   {31'b0, busy_mask[5]}, 32'd1);
        idle(1);
        check("net_wb_d",   Result_WB, 32'hD);
        check("net_busy_d", {31'b0, busy_mask[5]}, 32'd1);
        idle(1);
        check("net_clear",  {31'b0, busy_mask[5]}, 32'd0);

        // Random traffic with occasional reset
        for (int k = 0; k < 600; k++) begin
            tick($urandom_range(99) < 3,
                 $urandom_range(99) < 60, $urandom_range(15), $urandom,
                 $urandom_range(99) < 60, $urandom_range(15), $urandom);
        end
        idle(12);
        check("drain_busy", {16'b0, busy_mask}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
